// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types and constants used by the lap recorder slice.
package stopwatch_pkg;

    localparam int TIME_W            = 16;
    localparam int DEFAULT_LAP_DEPTH = 8;

    typedef enum logic {
        LAP_LIVE   = 1'b0,
        LAP_RECALL = 1'b1
    } lap_state_t;

endpackage

// File: rtl/lap_recorder_if.sv
// Control pulses, live time input and display/status outputs of one lap recorder channel.
interface lap_recorder_if
    import stopwatch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_LAP_DEPTH,
    parameter int W     = TIME_W
);
    logic                       clear;
    logic                       lap_store;
    logic                       recall;
    logic                       exit_recall;
    logic [W-1:0]               live_time;
    logic [W-1:0]               display_time;
    logic                       recall_active;
    logic [$clog2(DEPTH)-1:0]   lap_index;
    logic [$clog2(DEPTH):0]     lap_count;
    logic                       full;
    logic                       empty;
    logic                       overflow;

    modport master (
        output clear, lap_store, recall, exit_recall, live_time,
        input  display_time, recall_active, lap_index, lap_count, full, empty, overflow
    );

    modport slave (
        input  clear, lap_store, recall, exit_recall, live_time,
        output display_time, recall_active, lap_index, lap_count, full, empty, overflow
    );

endinterface

// File: rtl/lap_ram.sv
// DEPTH x W lap storage: one synchronous write port, one asynchronous read port, no reset.
module lap_ram #(
    parameter int DEPTH = 8,
    parameter int W     = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lap_recorder.sv
// Lap/split memory controller: captures live time into a lap buffer and selects LIVE or RECALL display.
// Define LAP_OVERWRITE_EN to make a store into a full buffer overwrite the oldest lap.
module lap_recorder
    import stopwatch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_LAP_DEPTH,
    parameter int W     = TIME_W
) (
    input  logic         clk,
    input  logic         reset_n,
    lap_recorder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    lap_state_t    state, state_next;
    logic [AW-1:0] wr_ptr, wr_ptr_next;
    logic [AW-1:0] rd_base, rd_base_next;
    logic [AW-1:0] index, index_next;
    logic [CW-1:0] count, count_next;
    logic          overflow, overflow_next;
    logic [W-1:0]  display, display_next;
    logic          we;
    logic [AW-1:0] raddr;
    logic [W-1:0]  rdata;
    logic          is_full, is_empty;

    assign is_full  = (count == FULL_COUNT);
    assign is_empty = (count == '0);

    lap_ram #(.DEPTH(DEPTH), .W(W)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (bus.live_time),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= LAP_LIVE;
            wr_ptr   <= '0;
            rd_base  <= '0;
            index    <= '0;
            count    <= '0;
            overflow <= 1'b0;
            display  <= '0;
        end else begin
            state    <= state_next;
            wr_ptr   <= wr_ptr_next;
            rd_base  <= rd_base_next;
            index    <= index_next;
            count    <= count_next;
            overflow <= overflow_next;
            display  <= display_next;
        end
    end

    // Only the highest-priority pending command acts: clear > lap_store > exit_recall > recall.
    always_comb begin
        state_next    = state;
        wr_ptr_next   = wr_ptr;
        rd_base_next  = rd_base;
        index_next    = index;
        count_next    = count;
        overflow_next = overflow;
        we            = 1'b0;
        if (bus.clear) begin
            state_next    = LAP_LIVE;
            wr_ptr_next   = '0;
            rd_base_next  = '0;
            index_next    = '0;
            count_next    = '0;
            overflow_next = 1'b0;
        end else if (bus.lap_store) begin
            if (!is_full) begin
                we          = 1'b1;
                wr_ptr_next = wr_ptr + 1'b1;
                count_next  = count + 1'b1;
            end else begin
                overflow_next = 1'b1;
`ifdef LAP_OVERWRITE_EN
                we           = 1'b1;
                wr_ptr_next  = wr_ptr + 1'b1;
                rd_base_next = rd_base + 1'b1;
`endif
            end
        end else if (bus.exit_recall) begin
            if (state == LAP_RECALL) begin
                state_next = LAP_LIVE;
            end
        end else if (bus.recall) begin
            if (state == LAP_LIVE) begin
                if (!is_empty) begin
                    state_next = LAP_RECALL;
                    index_next = '0;
                end
            end else if ({1'b0, index} == count - 1'b1) begin
                index_next = '0;
            end else begin
                index_next = index + 1'b1;
            end
        end
    end

    assign raddr = rd_base_next + index_next;

    // A same-cycle overwrite of the slot being shown must display the new word, not the stale one.
    always_comb begin
        display_next = rdata;
        if (state_next == LAP_LIVE) begin
            display_next = bus.live_time;
        end else if (we && (wr_ptr == raddr)) begin
            display_next = bus.live_time;
        end
    end

    assign bus.display_time  = display;
    assign bus.recall_active = (state == LAP_RECALL);
    assign bus.lap_index     = index;
    assign bus.lap_count     = count;
    assign bus.full          = is_full;
    assign bus.empty         = is_empty;
    assign bus.overflow      = overflow;

endmodule

// File: tb/tb_lap_recorder.sv
// Directed, table-driven bench for lap_recorder (DEPTH=8, W=16); honours LAP_OVERWRITE_EN.
module tb_lap_recorder;
    import stopwatch_pkg::*;

    localparam int DEPTH = 8;
    localparam int W     = 16;

    typedef struct {
        logic        clear;
        logic        lap_store;
        logic        recall;
        logic        exit_recall;
        logic [15:0] live;
        logic [15:0] disp;
        logic        act;
        logic [2:0]  idx;
        logic [3:0]  cnt;
        logic        ovf;
    } vec_t;

    localparam int NVEC = 16;

    logic clk;
    logic reset_n;
    int   passed;
    int   total;
    vec_t vecs [NVEC];

    lap_recorder_if #(.DEPTH(DEPTH), .W(W)) bus ();

    lap_recorder #(.DEPTH(DEPTH), .W(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string name, input int actual, input int expected);
        total++;
        if (actual == expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic check_output(input string tag, input logic [15:0] disp, input logic act,
                                input logic [2:0] idx, input logic [3:0] cnt, input logic ovf);
        check_val({tag, ".display_time"},  int'(bus.display_time),  int'(disp));
        check_val({tag, ".recall_active"}, int'(bus.recall_active), int'(act));
        check_val({tag, ".lap_index"},     int'(bus.lap_index),     int'(idx));
        check_val({tag, ".lap_count"},     int'(bus.lap_count),     int'(cnt));
        check_val({tag, ".full"},          int'(bus.full),          int'(cnt == 4'd8));
        check_val({tag, ".empty"},         int'(bus.empty),         int'(cnt == 4'd0));
        check_val({tag, ".overflow"},      int'(bus.overflow),      int'(ovf));
    endtask

    // One clock with the given pulses; live_time stays at its new value afterwards.
    task automatic apply_stimulus(input logic c, input logic s, input logic r, input logic e,
                                  input logic [15:0] live);
        bus.clear       = c;
        bus.lap_store   = s;
        bus.recall      = r;
        bus.exit_recall = e;
        bus.live_time   = live;
        @(posedge clk);
        #1;
        bus.clear       = 1'b0;
        bus.lap_store   = 1'b0;
        bus.recall      = 1'b0;
        bus.exit_recall = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] first_lap;
        passed = 0;
        total  = 0;

`ifdef LAP_OVERWRITE_EN
        first_lap = 16'h0002;
`else
        first_lap = 16'h0001;
`endif

        //            clr   st    rc    ex    live      disp      act   idx   cnt   ovf
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h1234, 1'b0, 3'd0, 4'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h1234, 1'b0, 3'd0, 4'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0123, 16'h0123, 1'b0, 3'd0, 4'd1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0456, 16'h0456, 1'b0, 3'd0, 4'd2, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0789, 16'h0789, 1'b0, 3'd0, 4'd3, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h5555, 16'h0123, 1'b1, 3'd0, 4'd3, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h5555, 16'h0456, 1'b1, 3'd1, 4'd3, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h5555, 16'h0789, 1'b1, 3'd2, 4'd3, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h5555, 16'h0123, 1'b1, 3'd0, 4'd3, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0999, 16'h0123, 1'b1, 3'd0, 4'd4, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h4321, 16'h4321, 1'b0, 3'd0, 4'd4, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h4321, 16'h4321, 1'b0, 3'd0, 4'd4, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h4321, 16'h0123, 1'b1, 3'd0, 4'd4, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h4321, 16'h0456, 1'b1, 3'd1, 4'd4, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h4321, 16'h4321, 1'b0, 3'd1, 4'd4, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h7777, 16'h7777, 1'b0, 3'd0, 4'd0, 1'b0};

        reset_n         = 1'b0;
        bus.clear       = 1'b0;
        bus.lap_store   = 1'b0;
        bus.recall      = 1'b0;
        bus.exit_recall = 1'b0;
        bus.live_time   = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset", 16'h0000, 1'b0, 3'd0, 4'd0, 1'b0);
        reset_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(vecs[i].clear, vecs[i].lap_store, vecs[i].recall,
                           vecs[i].exit_recall, vecs[i].live);
            check_output($sformatf("vec%0d", i), vecs[i].disp, vecs[i].act,
                         vecs[i].idx, vecs[i].cnt, vecs[i].ovf);
        end

        // Reset asserted while recalling a 3-lap buffer.
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0011);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0022);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0033);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0044);
        check_output("pre_reset", 16'h0011, 1'b1, 3'd0, 4'd3, 1'b0);
        #2 reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_output("mid_recall_reset", 16'h0000, 1'b0, 3'd0, 4'd0, 1'b0);
        reset_n = 1'b1;

        // Nine stores into an eight-entry buffer.
        for (int i = 1; i <= 9; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'(i));
            if (i == 8) check_output("store8", 16'h0008, 1'b0, 3'd0, 4'd8, 1'b0);
        end
        check_output("store9", 16'h0009, 1'b0, 3'd0, 4'd8, 1'b1);
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
            check_output($sformatf("full_recall%0d", k), first_lap + 16'(k), 1'b1,
                         3'(k), 4'd8, 1'b1);
        end
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        check_output("full_wrap", first_lap, 1'b1, 3'd0, 4'd8, 1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0abc);
        check_output("clear_ovf", 16'h0abc, 1'b0, 3'd0, 4'd0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
